// File: rtl/sdio_pkg.sv
// Shared types and constants for the 3-wire SDIO register-bus target.
package sdio_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, TA, RDATA} sdio_state_e;
  localparam logic SDIO_RW_READ   = 1'b1;
  localparam int   SDIO_TA_CYCLES = 1;
endpackage

// File: rtl/sdio_if.sv
// Serial pad side plus register-bank strobes of the SDIO target.
interface sdio_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              cs_n;
  logic              sdio_in;
  logic              sdio_out;
  logic              sdio_oe;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              frame_err;
  logic              busy;

  modport slave (
    input  cs_n, sdio_in, rd_data,
    output sdio_out, sdio_oe, wr_en, wr_addr, wr_data, rd_en, rd_addr, frame_err, busy
  );
  modport master (
    output cs_n, sdio_in, rd_data,
    input  sdio_out, sdio_oe, wr_en, wr_addr, wr_data, rd_en, rd_addr, frame_err, busy
  );
endinterface

// File: rtl/sdio_shift_reg.sv
// Data shifter: parallel load, serial in at the LSB, MSB-first serial out on q[W-1].
module sdio_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic         sin,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= '0;
    else if (load)  q <= din;
    else if (shift) q <= {q[W-2:0], sin};
  end
endmodule

// File: rtl/sdio_target.sv
// Responder for the half-duplex SDIO register bus: frame decode, write/read strobes
// to the register bank, and read data serialised back onto the pad.
module sdio_target
  import sdio_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input logic   sclk,
  input logic   rst,
  sdio_if.slave bus
);
  localparam int MAXW  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(MAXW + 1);

  sdio_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic              oe_q, oe_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              ferr_q, ferr_d;
  logic              busy_q, busy_d;

  logic              sr_load, sr_shift, sr_sin;
  logic [DATA_W-1:0] sr_q;

  // One shifter serves both directions: write bits enter at the LSB, read bits
  // leave from the MSB. Its MSB is only meaningful on the pad while oe is set.
  sdio_shift_reg #(.W(DATA_W)) u_sr (
    .clk   (sclk),
    .rst   (rst),
    .load  (sr_load),
    .shift (sr_shift),
    .sin   (sr_sin),
    .din   (bus.rd_data),
    .q     (sr_q)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    oe_d      = 1'b0;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    ferr_d    = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    sr_sin    = 1'b0;

    if (state_q != IDLE && bus.cs_n) begin
      // Deselect: only a frame cut inside a word counts as an error.
      state_d = IDLE;
      cnt_d   = '0;
      ferr_d  = (state_q == ADDR) ||
                ((state_q == WDATA || state_q == RDATA) && cnt_q != '0);
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.cs_n) begin
            rw_d    = bus.sdio_in;
            state_d = ADDR;
            cnt_d   = '0;
          end
        end
        ADDR: begin
          addr_d = {addr_q[ADDR_W-2:0], bus.sdio_in};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ADDR_W - 1)) begin
            cnt_d = '0;
            if (rw_q == SDIO_RW_READ) begin
              state_d   = TA;
              rd_en_d   = 1'b1;
              rd_addr_d = addr_d;
            end else begin
              state_d = WDATA;
            end
          end
        end
        WDATA: begin
          sr_shift = 1'b1;
          sr_sin   = bus.sdio_in;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d     = '0;
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = {sr_q[DATA_W-2:0], bus.sdio_in};
            addr_d    = addr_q + ADDR_W'(1);
          end
        end
        TA: begin
          sr_load = 1'b1;
          oe_d    = 1'b1;
          state_d = RDATA;
          cnt_d   = '0;
        end
        RDATA: begin
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            // Word done: prefetch the next address behind a fresh turnaround.
            state_d   = TA;
            cnt_d     = '0;
            addr_d    = addr_q + ADDR_W'(1);
            rd_en_d   = 1'b1;
            rd_addr_d = addr_q + ADDR_W'(1);
          end else begin
            sr_shift = 1'b1;
            oe_d     = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      oe_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      oe_q      <= oe_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.sdio_out  = sr_q[DATA_W-1];
  assign bus.sdio_oe   = oe_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_sdio_target.sv
// Bench for sdio_target: initiator tasks drive frames; a bank model plus a reference
// memory predict strobes and read data word by word.
module tb_sdio_target;
  typedef struct { logic [6:0] a; logic [7:0] d; int cyc; } wr_ev_t;

  logic sclk = 1'b0;
  logic rst;
  logic m_oe, m_out;
  int   total = 0, bad = 0;
  int   cyc = 0, ferr_cnt = 0, oe_cnt = 0, contention = 0;

  wr_ev_t     wr_q[$];
  logic [7:0] bank[128];
  bit         bank_vld[128];
  logic [7:0] ref_mem[128];
  logic [7:0] wbuf[8], rbuf[8];
  int         lastcyc[8];
  logic       ta_oe[9], ta_rden[9];
  logic [6:0] ta_rdaddr[9];
  int         rd_oe_bad;

  sdio_if #(.ADDR_W(7), .DATA_W(8)) bus();
  sdio_target #(.ADDR_W(7), .DATA_W(8)) dut (.sclk(sclk), .rst(rst), .bus(bus));

  always #5 sclk = ~sclk;

  function automatic logic [7:0] init_val(input logic [6:0] a);
    logic [7:0] v;
    v = {1'b0, a};
    return v * 8'd37 + 8'd5;
  endfunction

  // Pad resolution with a pull-up; bank read data is combinational from rd_addr.
  assign bus.sdio_in = bus.sdio_oe ? bus.sdio_out : (m_oe ? m_out : 1'b1);
  assign bus.rd_data = bank_vld[bus.rd_addr] ? bank[bus.rd_addr] : init_val(bus.rd_addr);

  always @(posedge sclk) cyc <= cyc + 1;

  always @(negedge sclk) begin
    if (bus.wr_en) begin
      wr_q.push_back('{bus.wr_addr, bus.wr_data, cyc});
      bank[bus.wr_addr]     <= bus.wr_data;
      bank_vld[bus.wr_addr] <= 1'b1;
    end
    if (bus.frame_err) ferr_cnt <= ferr_cnt + 1;
    if (bus.sdio_oe) oe_cnt <= oe_cnt + 1;
    if (bus.sdio_oe && m_oe) contention <= contention + 1;
    #2;
    if (bus.sdio_oe && m_oe) contention <= contention + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic bit_cycle(input logic cs, input logic drv, input logic v);
    @(negedge sclk); #1;
    bus.cs_n = cs; m_oe = drv; m_out = v;
    @(posedge sclk); #1;
  endtask

  task automatic write_frame(input logic [6:0] a, input int n);
    bit_cycle(1'b0, 1'b1, 1'b0);
    for (int i = 6; i >= 0; i--) bit_cycle(1'b0, 1'b1, a[i]);
    for (int k = 0; k < n; k++)
      for (int i = 7; i >= 0; i--) begin
        bit_cycle(1'b0, 1'b1, wbuf[k][i]);
        if (i == 0) lastcyc[k] = cyc;
      end
    bit_cycle(1'b1, 1'b0, 1'b0);
  endtask

  // Each word: TA, 8 bits observed after each edge, then the edge back into TA.
  // The frame ends in TA so the deselect lands on a clean boundary.
  task automatic read_frame(input logic [6:0] a, input int n);
    bit_cycle(1'b0, 1'b1, 1'b1);
    for (int i = 6; i >= 0; i--) bit_cycle(1'b0, 1'b1, a[i]);
    ta_oe[0] = bus.sdio_oe; ta_rden[0] = bus.rd_en; ta_rdaddr[0] = bus.rd_addr;
    rd_oe_bad = 0;
    for (int k = 0; k < n; k++) begin
      for (int i = 7; i >= 0; i--) begin
        bit_cycle(1'b0, 1'b0, 1'b0);
        rbuf[k][i] = bus.sdio_out;
        if (bus.sdio_oe !== 1'b1) rd_oe_bad++;
      end
      bit_cycle(1'b0, 1'b0, 1'b0);
      ta_oe[k+1] = bus.sdio_oe; ta_rden[k+1] = bus.rd_en; ta_rdaddr[k+1] = bus.rd_addr;
    end
    bit_cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.cs_n = 1'b1; m_oe = 1'b0; m_out = 1'b0;
    repeat (2) @(posedge sclk); #1;
    total++;
    if ({bus.sdio_oe, bus.sdio_out, bus.wr_en, bus.rd_en, bus.frame_err} !== 5'b0) begin
      bad++; $display("FAIL reset_strobes: got %b want 00000",
        {bus.sdio_oe, bus.sdio_out, bus.wr_en, bus.rd_en, bus.frame_err});
    end
    total++;
    if ({bus.wr_addr, bus.wr_data, bus.rd_addr} !== 22'b0) begin
      bad++; $display("FAIL reset_buses: got %h want 0", {bus.wr_addr, bus.wr_data, bus.rd_addr});
    end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    @(negedge sclk); rst = 1'b0;
    bit_cycle(1'b1, 1'b0, 1'b0);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_single_write;
    int wb, oe0;
    wb = wr_q.size(); oe0 = oe_cnt;
    wbuf[0] = 8'hA5;
    write_frame(7'h15, 1);
    ref_mem[7'h15] = 8'hA5;
    total++;
    if (wr_q.size() != wb + 1) begin
      bad++; $display("FAIL sw_count: got %0d want 1", wr_q.size() - wb);
    end else begin
      total++;
      if (wr_q[wb].a !== 7'h15 || wr_q[wb].d !== 8'hA5) begin
        bad++; $display("FAIL sw_data: got %h/%h want 15/a5", wr_q[wb].a, wr_q[wb].d);
      end
      total++;
      if (wr_q[wb].cyc != lastcyc[0]) begin
        bad++; $display("FAIL sw_latency: got cycle %0d want %0d", wr_q[wb].cyc, lastcyc[0]);
      end
    end
    total++;
    if (oe_cnt != oe0) begin bad++; $display("FAIL sw_oe: got %0d oe cycles want 0", oe_cnt - oe0); end
    total++;
    if (bus.busy !== 1'b0 || bus.frame_err !== 1'b0) begin
      bad++; $display("FAIL sw_end: got busy=%b err=%b want 0/0", bus.busy, bus.frame_err);
    end
  endtask

  task automatic test_single_read;
    wbuf[0] = 8'h3C;
    write_frame(7'h03, 1);
    ref_mem[7'h03] = 8'h3C;
    read_frame(7'h03, 1);
    total++;
    if (ta_oe[0] !== 1'b0 || ta_rden[0] !== 1'b1 || ta_rdaddr[0] !== 7'h03) begin
      bad++; $display("FAIL sr_ta: got oe=%b rd_en=%b addr=%h want 0/1/03", ta_oe[0], ta_rden[0], ta_rdaddr[0]);
    end
    total++;
    if (rbuf[0] !== 8'h3C) begin bad++; $display("FAIL sr_data: got %b want 00111100", rbuf[0]); end
    total++;
    if (rd_oe_bad != 0) begin bad++; $display("FAIL sr_oe_drive: got %0d undriven bits want 0", rd_oe_bad); end
    total++;
    if (bus.sdio_oe !== 1'b0 || bus.frame_err !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL sr_release: got oe=%b err=%b busy=%b want 0/0/0", bus.sdio_oe, bus.frame_err, bus.busy);
    end
  endtask

  task automatic test_burst_write;
    int wb;
    logic [6:0] ea;
    wb = wr_q.size();
    for (int k = 0; k < 3; k++) wbuf[k] = 8'($urandom);
    write_frame(7'h7F, 3);
    total++;
    if (wr_q.size() != wb + 3) begin
      bad++; $display("FAIL bw_count: got %0d want 3", wr_q.size() - wb);
    end else begin
      for (int k = 0; k < 3; k++) begin
        ea = 7'(7'h7F + k);
        total++;
        if (wr_q[wb+k].a !== ea || wr_q[wb+k].d !== wbuf[k]) begin
          bad++; $display("FAIL bw_word%0d: got %h/%h want %h/%h", k, wr_q[wb+k].a, wr_q[wb+k].d, ea, wbuf[k]);
        end
      end
    end
    for (int k = 0; k < 3; k++) ref_mem[7'(7'h7F + k)] = wbuf[k];
  endtask

  task automatic test_burst_read;
    read_frame(7'h10, 2);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (ta_rdaddr[k] !== 7'(7'h10 + k) || ta_rden[k] !== 1'b1 || ta_oe[k] !== 1'b0) begin
        bad++; $display("FAIL br_ta%0d: got addr=%h rd_en=%b oe=%b want %h/1/0",
          k, ta_rdaddr[k], ta_rden[k], ta_oe[k], 7'(7'h10 + k));
      end
      total++;
      if (rbuf[k] !== ref_mem[7'(7'h10 + k)]) begin
        bad++; $display("FAIL br_data%0d: got %h want %h", k, rbuf[k], ref_mem[7'(7'h10 + k)]);
      end
    end
    total++;
    if (rd_oe_bad != 0) begin bad++; $display("FAIL br_oe_drive: got %0d undriven bits want 0", rd_oe_bad); end
  endtask

  task automatic test_abort;
    int wb, f0;
    logic [6:0] a;
    wb = wr_q.size(); f0 = ferr_cnt;
    a = 7'h2A;
    bit_cycle(1'b0, 1'b1, 1'b0);
    for (int i = 6; i >= 0; i--) bit_cycle(1'b0, 1'b1, a[i]);
    for (int i = 0; i < 4; i++) bit_cycle(1'b0, 1'b1, 1'(i));
    bit_cycle(1'b1, 1'b0, 1'b0);
    total++;
    if (bus.frame_err !== 1'b1 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL ab_mid: got err=%b busy=%b want 1/0", bus.frame_err, bus.busy);
    end
    bit_cycle(1'b1, 1'b0, 1'b0);
    total++;
    if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL ab_pulse: got %b want 0", bus.frame_err); end
    // Deselect on the edge carrying the last data bit: that bit is not valid.
    a = 7'h2B;
    bit_cycle(1'b0, 1'b1, 1'b0);
    for (int i = 6; i >= 0; i--) bit_cycle(1'b0, 1'b1, a[i]);
    for (int i = 0; i < 7; i++) bit_cycle(1'b0, 1'b1, 1'b1);
    bit_cycle(1'b1, 1'b1, 1'b1);
    total++;
    if (bus.frame_err !== 1'b1 || bus.wr_en !== 1'b0) begin
      bad++; $display("FAIL ab_lastbit: got err=%b wr_en=%b want 1/0", bus.frame_err, bus.wr_en);
    end
    bit_cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) bit_cycle(1'b0, 1'b1, 1'b1);
    bit_cycle(1'b1, 1'b0, 1'b0);
    total++;
    if (bus.frame_err !== 1'b1) begin bad++; $display("FAIL ab_addr: got %b want 1", bus.frame_err); end
    bit_cycle(1'b1, 1'b0, 1'b0);
    total++;
    if (ferr_cnt - f0 != 3 || wr_q.size() != wb) begin
      bad++; $display("FAIL ab_totals: got err=%0d wr=%0d want 3/0", ferr_cnt - f0, wr_q.size() - wb);
    end
    wbuf[0] = 8'($urandom);
    write_frame(7'h2C, 1);
    ref_mem[7'h2C] = wbuf[0];
    total++;
    if (wr_q.size() != wb + 1 || wr_q[wr_q.size()-1].a !== 7'h2C || wr_q[wr_q.size()-1].d !== wbuf[0]) begin
      bad++; $display("FAIL ab_recover: got %0d writes want 1 at 2c/%h", wr_q.size() - wb, wbuf[0]);
    end
  endtask

  task automatic test_rst_mid;
    int c0, wb;
    logic [6:0] a;
    c0 = contention; a = 7'h22;
    bit_cycle(1'b0, 1'b1, 1'b1);
    for (int i = 6; i >= 0; i--) bit_cycle(1'b0, 1'b1, a[i]);
    repeat (3) bit_cycle(1'b0, 1'b0, 1'b0);
    total++;
    if (bus.sdio_oe !== 1'b1) begin bad++; $display("FAIL rm_driving: got oe=%b want 1", bus.sdio_oe); end
    rst = 1'b1; #1;
    total++;
    if ({bus.sdio_oe, bus.sdio_out, bus.wr_en, bus.rd_en, bus.frame_err, bus.busy} !== 6'b0) begin
      bad++; $display("FAIL rm_async: got %b want 000000",
        {bus.sdio_oe, bus.sdio_out, bus.wr_en, bus.rd_en, bus.frame_err, bus.busy});
    end
    bus.cs_n = 1'b1; m_oe = 1'b1; m_out = 1'b0;
    repeat (2) @(posedge sclk);
    @(negedge sclk); rst = 1'b0;
    wb = wr_q.size();
    wbuf[0] = 8'($urandom);
    write_frame(7'h33, 1);
    ref_mem[7'h33] = wbuf[0];
    total++;
    if (wr_q.size() != wb + 1 || wr_q[wr_q.size()-1].d !== wbuf[0]) begin
      bad++; $display("FAIL rm_next_frame: got %0d writes want 1 with %h", wr_q.size() - wb, wbuf[0]);
    end
    total++;
    if (contention != c0) begin bad++; $display("FAIL rm_contention: got %0d want 0", contention - c0); end
  endtask

  task automatic test_random;
    int wb, n;
    logic [6:0] a, ea;
    for (int it = 0; it < 16; it++) begin
      a = 7'($urandom);
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 0) begin
        wb = wr_q.size();
        for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
        write_frame(a, n);
        total++;
        if (wr_q.size() != wb + n) begin
          bad++; $display("FAIL rnd_wr_count: got %0d want %0d", wr_q.size() - wb, n);
        end else begin
          for (int k = 0; k < n; k++) begin
            ea = 7'(a + k);
            total++;
            if (wr_q[wb+k].a !== ea || wr_q[wb+k].d !== wbuf[k] || wr_q[wb+k].cyc != lastcyc[k]) begin
              bad++; $display("FAIL rnd_wr: got %h/%h@%0d want %h/%h@%0d",
                wr_q[wb+k].a, wr_q[wb+k].d, wr_q[wb+k].cyc, ea, wbuf[k], lastcyc[k]);
            end
          end
        end
        for (int k = 0; k < n; k++) ref_mem[7'(a + k)] = wbuf[k];
      end else begin
        read_frame(a, n);
        for (int k = 0; k < n; k++) begin
          ea = 7'(a + k);
          total++;
          if (rbuf[k] !== ref_mem[ea] || ta_rdaddr[k] !== ea || ta_oe[k] !== 1'b0 || ta_rden[k] !== 1'b1) begin
            bad++; $display("FAIL rnd_rd: got %h at %h (oe=%b rd_en=%b) want %h at %h",
              rbuf[k], ta_rdaddr[k], ta_oe[k], ta_rden[k], ref_mem[ea], ea);
          end
        end
        total++;
        if (rd_oe_bad != 0) begin bad++; $display("FAIL rnd_rd_oe: got %0d undriven bits want 0", rd_oe_bad); end
      end
      total++;
      if (bus.frame_err !== 1'b0 || bus.busy !== 1'b0 || bus.sdio_oe !== 1'b0) begin
        bad++; $display("FAIL rnd_end: got err=%b busy=%b oe=%b want 0/0/0", bus.frame_err, bus.busy, bus.sdio_oe);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = init_val(7'(i));
    test_reset;
    test_single_write;
    test_single_read;
    test_burst_write;
    test_burst_read;
    test_abort;
    test_rst_mid;
    test_random;
    @(negedge sclk); #3;
    total++;
    if (contention != 0) begin bad++; $display("FAIL contention: got %0d want 0", contention); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
